// File: rtl/game_flow_ctrl.sv
// Pinball game flow controller: start/pause, respawn delay, levels, lives, saturating score, game over and win.
// Optional build macro GAME_FLOW_BAD_HIT_LIFE_EN makes a bad hit cost a life instead of a point.
module game_flow_ctrl #(
    parameter int NUM_LEVELS     = 4,
    parameter int NUM_LIVES      = 3,
    parameter int HITS_PER_LEVEL = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SCORE_W        = 4,
    parameter int LEVEL_W        = 4,
    parameter int LIFE_W         = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               key5IsPressed,
    input  logic               collisionSmileyBorderBottom,
    input  logic               collisionSmileyObstacleGood,
    input  logic               collisionSmileyObstacleBad,
    output logic               pause,
    output logic               reset_level,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [LIFE_W-1:0]  life,
    output logic               game_over,
    output logic               game_won
);

    localparam int HIT_W   = $clog2(HITS_PER_LEVEL + 1);
    localparam int FRAME_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIFE_W-1:0]  FULL_LIFE  = LIFE_W'(NUM_LIVES);
    localparam logic [HIT_W-1:0]   LAST_HIT   = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(RESPAWN_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        PAUSED,
        RESPAWN,
        GAME_OVER,
        WIN
    } state_t;

    state_t             state;
    logic [HIT_W-1:0]   hit_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               key_prev;
    logic               arm_bottom;
    logic               arm_good;
    logic               arm_bad;

    logic key_edge;
    logic fire_bottom;
    logic fire_good;
    logic fire_bad;
    logic act_good;
    logic act_bad;
    logic lose_life;
    logic bad_dec;

    // Output pattern {pause, reset_level, game_over, game_won} for the state being entered.
    function automatic logic [3:0] state_outs(state_t s);
        case (s)
            IDLE:      return 4'b1100;
            PLAY:      return 4'b0000;
            PAUSED:    return 4'b1000;
            RESPAWN:   return 4'b1100;
            GAME_OVER: return 4'b1010;
            WIN:       return 4'b1001;
            default:   return 4'b1100;
        endcase
    endfunction

    assign key_edge    = key5IsPressed & ~key_prev;
    assign fire_bottom = collisionSmileyBorderBottom & arm_bottom;
    assign fire_bad    = collisionSmileyObstacleBad & arm_bad;
    assign fire_good   = collisionSmileyObstacleGood & arm_good;
    assign act_bad     = fire_bad & ~fire_bottom;
    assign act_good    = fire_good & ~fire_bottom & ~fire_bad;

`ifdef GAME_FLOW_BAD_HIT_LIFE_EN
    assign lose_life = fire_bottom | act_bad;
    assign bad_dec   = 1'b0;
`else
    assign lose_life = fire_bottom;
    assign bad_dec   = act_bad;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            pause       <= 1'b1;
            reset_level <= 1'b1;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            score       <= '0;
            level       <= '0;
            life        <= FULL_LIFE;
            hit_cnt     <= '0;
            frame_cnt   <= '0;
            key_prev    <= 1'b0;
            arm_bottom  <= 1'b1;
            arm_good    <= 1'b1;
            arm_bad     <= 1'b1;
        end else begin
            key_prev <= key5IsPressed;
            // A firing clears its arm, but a coincident frame start wins so the arm ends up set.
            arm_bottom <= startOfFrame | (arm_bottom & ~collisionSmileyBorderBottom);
            arm_good   <= startOfFrame | (arm_good & ~collisionSmileyObstacleGood);
            arm_bad    <= startOfFrame | (arm_bad & ~collisionSmileyObstacleBad);

            case (state)
                IDLE: begin
                    if (key_edge) begin
                        state <= PLAY;
                        {pause, reset_level, game_over, game_won} <= state_outs(PLAY);
                    end
                end

                PLAY: begin
                    if (key_edge) begin
                        state <= PAUSED;
                        {pause, reset_level, game_over, game_won} <= state_outs(PAUSED);
                    end else if (lose_life) begin
                        life <= life - 1'b1;
                        if (life == LIFE_W'(1)) begin
                            state <= GAME_OVER;
                            {pause, reset_level, game_over, game_won} <= state_outs(GAME_OVER);
                        end else begin
                            state     <= RESPAWN;
                            frame_cnt <= '0;
                            {pause, reset_level, game_over, game_won} <= state_outs(RESPAWN);
                        end
                    end else if (act_good) begin
                        if (score != SCORE_MAX) begin
                            score <= score + 1'b1;
                        end
                        if (hit_cnt == LAST_HIT) begin
                            hit_cnt <= '0;
                            if (level == LAST_LEVEL) begin
                                state <= WIN;
                                {pause, reset_level, game_over, game_won} <= state_outs(WIN);
                            end else begin
                                level     <= level + 1'b1;
                                state     <= RESPAWN;
                                frame_cnt <= '0;
                                {pause, reset_level, game_over, game_won} <= state_outs(RESPAWN);
                            end
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end else if (bad_dec) begin
                        if (score != '0) begin
                            score <= score - 1'b1;
                        end
                    end
                end

                PAUSED: begin
                    if (key_edge) begin
                        state <= PLAY;
                        {pause, reset_level, game_over, game_won} <= state_outs(PLAY);
                    end
                end

                RESPAWN: begin
                    if (startOfFrame) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt <= '0;
                            state     <= PLAY;
                            {pause, reset_level, game_over, game_won} <= state_outs(PLAY);
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                GAME_OVER, WIN: begin
                    if (key_edge) begin
                        state   <= IDLE;
                        score   <= '0;
                        level   <= '0;
                        life    <= FULL_LIFE;
                        hit_cnt <= '0;
                        {pause, reset_level, game_over, game_won} <= state_outs(IDLE);
                    end
                end

                default: begin
                    state <= IDLE;
                    {pause, reset_level, game_over, game_won} <= state_outs(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default parameters.
// Expectations follow GAME_FLOW_BAD_HIT_LIFE_EN the same way the design does.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       key5IsPressed = 1'b0;
    logic       collisionSmileyBorderBottom = 1'b0;
    logic       collisionSmileyObstacleGood = 1'b0;
    logic       collisionSmileyObstacleBad = 1'b0;
    logic       pause;
    logic       reset_level;
    logic [3:0] score;
    logic [3:0] level;
    logic [3:0] life;
    logic       game_over;
    logic       game_won;

    int vec_count = 0;
    int miscompares = 0;
    int exp_score;
    int exp_life;

    game_flow_ctrl dut (
        .clk                         (clk),
        .resetN                      (resetN),
        .startOfFrame                (startOfFrame),
        .key5IsPressed               (key5IsPressed),
        .collisionSmileyBorderBottom (collisionSmileyBorderBottom),
        .collisionSmileyObstacleGood (collisionSmileyObstacleGood),
        .collisionSmileyObstacleBad  (collisionSmileyObstacleBad),
        .pause                       (pause),
        .reset_level                 (reset_level),
        .score                       (score),
        .level                       (level),
        .life                        (life),
        .game_over                   (game_over),
        .game_won                    (game_won)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic key, input logic sof, input logic bottom,
                                 input logic good, input logic bad);
        key5IsPressed               = key;
        startOfFrame                = sof;
        collisionSmileyBorderBottom = bottom;
        collisionSmileyObstacleGood = good;
        collisionSmileyObstacleBad  = bad;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic framePulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        quiet();
    endtask

    task automatic pressKey();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet();
    endtask

    task automatic hitGood();
        framePulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        quiet();
    endtask

    task automatic hitBottom();
        framePulse();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        quiet();
    endtask

    task automatic hitBad();
        framePulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        quiet();
    endtask

    // Respawn must last exactly 60 frame pulses.
    task automatic finishRespawn(input string tag);
        for (int i = 0; i < 59; i++) framePulse();
        checkOutput({tag, "_hold59"}, {31'd0, reset_level}, 32'd1);
        framePulse();
        checkOutput({tag, "_rl_done"}, {31'd0, reset_level}, 32'd0);
        checkOutput({tag, "_pause_done"}, {31'd0, pause}, 32'd0);
    endtask

    initial begin
        #1 resetN = 1'b0;
        #2;
        checkOutput("rst_pause", {31'd0, pause}, 32'd1);
        checkOutput("rst_reset_level", {31'd0, reset_level}, 32'd1);
        checkOutput("rst_score", {28'd0, score}, 32'd0);
        checkOutput("rst_level", {28'd0, level}, 32'd0);
        checkOutput("rst_life", {28'd0, life}, 32'd3);
        checkOutput("rst_game_over", {31'd0, game_over}, 32'd0);
        checkOutput("rst_game_won", {31'd0, game_won}, 32'd0);
        #19 resetN = 1'b1;
        quiet();
        quiet();

        // Start; holding the key must not toggle back to pause
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_pause", {31'd0, pause}, 32'd0);
        checkOutput("start_reset_level", {31'd0, reset_level}, 32'd0);
        checkOutput("start_life", {28'd0, life}, 32'd3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("key_held_pause", {31'd0, pause}, 32'd0);
        quiet();

        // Good collision held across many cycles counts once per frame
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("good_first", {28'd0, score}, 32'd1);
        for (int i = 0; i < 199; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("good_held_once", {28'd0, score}, 32'd1);
        quiet();
        framePulse();
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("good_next_frame", {28'd0, score}, 32'd2);
        quiet();

        // Third hit clears level 0
        hitGood();
        checkOutput("lvl1_score", {28'd0, score}, 32'd3);
        checkOutput("lvl1_level", {28'd0, level}, 32'd1);
        checkOutput("lvl1_reset_level", {31'd0, reset_level}, 32'd1);
        checkOutput("lvl1_pause", {31'd0, pause}, 32'd1);
        pressKey();
        checkOutput("respawn_key_ignored", {31'd0, pause}, 32'd1);
        finishRespawn("lvl1");

        for (int l = 2; l <= 3; l++) begin
            hitGood();
            hitGood();
            hitGood();
            checkOutput("lvl_up_level", {28'd0, level}, l);
            checkOutput("lvl_up_score", {28'd0, score}, 3 * l);
            finishRespawn("lvl_up");
        end

        hitGood();
        hitGood();
        hitGood();
        checkOutput("win_game_won", {31'd0, game_won}, 32'd1);
        checkOutput("win_score", {28'd0, score}, 32'd12);
        checkOutput("win_level", {28'd0, level}, 32'd3);
        checkOutput("win_reset_level", {31'd0, reset_level}, 32'd0);
        checkOutput("win_pause", {31'd0, pause}, 32'd1);

        pressKey();
        checkOutput("win_idle_won", {31'd0, game_won}, 32'd0);
        checkOutput("win_idle_score", {28'd0, score}, 32'd0);
        checkOutput("win_idle_level", {28'd0, level}, 32'd0);
        checkOutput("win_idle_reset_level", {31'd0, reset_level}, 32'd1);

        // Lose all three lives
        pressKey();
        hitBottom();
        checkOutput("life_2", {28'd0, life}, 32'd2);
        checkOutput("life_2_respawn", {31'd0, reset_level}, 32'd1);
        finishRespawn("life2");
        hitBottom();
        checkOutput("life_1", {28'd0, life}, 32'd1);
        finishRespawn("life1");
        hitBottom();
        checkOutput("life_0", {28'd0, life}, 32'd0);
        checkOutput("over_flag", {31'd0, game_over}, 32'd1);
        checkOutput("over_reset_level", {31'd0, reset_level}, 32'd0);
        pressKey();
        checkOutput("over_idle_flag", {31'd0, game_over}, 32'd0);
        checkOutput("over_idle_life", {28'd0, life}, 32'd3);
        checkOutput("over_idle_pause", {31'd0, pause}, 32'd1);

        // Reach score 5 with two hits toward level 2; second hit arrives with a frame start
        pressKey();
        hitGood();
        hitGood();
        hitGood();
        finishRespawn("p5");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("sof_fire_score", {28'd0, score}, 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sof_rearm_score", {28'd0, score}, 32'd5);
        quiet();

        framePulse();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        quiet();
        checkOutput("prio_life", {28'd0, life}, 32'd2);
        checkOutput("prio_score", {28'd0, score}, 32'd5);
        finishRespawn("prio");

`ifdef GAME_FLOW_BAD_HIT_LIFE_EN
        hitBad();
        checkOutput("bad_life", {28'd0, life}, 32'd1);
        checkOutput("bad_score_kept", {28'd0, score}, 32'd5);
        checkOutput("bad_respawn", {31'd0, reset_level}, 32'd1);
        finishRespawn("bad");
        exp_score = 5;
        exp_life  = 1;
`else
        framePulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        quiet();
        checkOutput("bad_over_good", {28'd0, score}, 32'd4);
        for (int i = 0; i < 4; i++) hitBad();
        checkOutput("bad_to_zero", {28'd0, score}, 32'd0);
        hitBad();
        checkOutput("bad_sat_zero", {28'd0, score}, 32'd0);
        checkOutput("bad_life_kept", {28'd0, life}, 32'd2);
        exp_score = 0;
        exp_life  = 2;
`endif

        // Pause ignores collisions
        pressKey();
        checkOutput("paused_pause", {31'd0, pause}, 32'd1);
        checkOutput("paused_reset_level", {31'd0, reset_level}, 32'd0);
        framePulse();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        quiet();
        checkOutput("paused_score", {28'd0, score}, exp_score);
        pressKey();
        checkOutput("resume_pause", {31'd0, pause}, 32'd0);

        // Third hit (good discarded earlier did not count) levels up into respawn
        hitGood();
        checkOutput("lvl2_level", {28'd0, level}, 32'd2);
        checkOutput("lvl2_score", {28'd0, score}, exp_score + 1);
        checkOutput("lvl2_life", {28'd0, life}, exp_life);
        for (int i = 0; i < 10; i++) framePulse();

        // Asynchronous reset mid-respawn, checked before any clock edge
        resetN = 1'b0;
        #2;
        checkOutput("async_pause", {31'd0, pause}, 32'd1);
        checkOutput("async_reset_level", {31'd0, reset_level}, 32'd1);
        checkOutput("async_score", {28'd0, score}, 32'd0);
        checkOutput("async_level", {28'd0, level}, 32'd0);
        checkOutput("async_life", {28'd0, life}, 32'd3);
        resetN = 1'b1;
        quiet();
        pressKey();
        checkOutput("post_reset_play", {31'd0, pause}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised successor to the pinball game controller. Owns the full game flow: start, pause, respawn delay, multi-level progression, life accounting, saturating score, game-over and win.
It sits in screen_main between CollisionDetector (event inputs) and the smiley, flipper and indications blocks (pause/reset_level/score/level/life consumers).
Collision inputs are per-pixel levels; this block reduces them to at most one event per type per frame.

Parameters:
NUM_LEVELS, 4, number of levels; level runs 0..NUM_LEVELS-1
NUM_LIVES, 3, lives at game start (>=1)
HITS_PER_LEVEL, 3, good-obstacle hits needed to clear a level (>=1)
RESPAWN_FRAMES, 60, frames reset_level is held after a life loss or level-up (>=1)
SCORE_W, 4, score width
LEVEL_W, 4, level width (must hold NUM_LEVELS-1)
LIFE_W, 4, life width (must hold NUM_LIVES)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
key5IsPressed  in  1  start/pause key level
collisionSmileyBorderBottom  in  1  ball lost (level, may be high many cycles)
collisionSmileyObstacleGood  in  1  ball hit good number (level)
collisionSmileyObstacleBad  in  1  ball hit bad number (level)
pause  out  1  freeze ball/flipper motion
reset_level  out  1  return ball/flipper to start positions
score  out  SCORE_W  current score
level  out  LEVEL_W  current level, 0-based
life  out  LIFE_W  remaining lives
game_over  out  1  high in GAME_OVER state
game_won  out  1  high in WIN state

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous and active-low.
- Reset values: state=IDLE, pause=1, reset_level=1, score=0, level=0, life=NUM_LIVES, game_over=0, game_won=0, hit counter=0, frame counter=0, key edge register=0, all event arms=1.
- All outputs are registered. Each output changes on the clk edge after the input cycle that causes the change.
- Key edge: a start/pause event is a rising edge of key5IsPressed (previous sample 0, current 1). Holding the key produces exactly one event.
- Event arming: each collision type has an arm flag. An event fires when its input is high and its arm is 1; the firing clears the arm. startOfFrame re-arms all three. An event that fires in the same cycle as startOfFrame still fires, and that arm ends the cycle set.
- Simultaneous events in one cycle: priority is bottom > bad > good. Only the highest-priority event is acted on; the lower events are consumed (arms cleared) and discarded.
- FSM states:
  - IDLE: pause=1, reset_level=1. Key edge -> PLAY.
  - PLAY: pause=0, reset_level=0.
    - Key edge -> PAUSED.
    - Bottom event: life-1. If life was 1 -> GAME_OVER (life=0). Otherwise -> RESPAWN.
    - Good event: score+1, saturating at 2^SCORE_W-1. Hit counter +1. When the counter reaches HITS_PER_LEVEL: counter=0; if level==NUM_LEVELS-1 -> WIN, else level+1 and -> RESPAWN.
    - Bad event: score-1, saturating at 0.
  - PAUSED: pause=1, reset_level=0. Collisions are ignored but arms are still cleared. Key edge -> PLAY.
  - RESPAWN: pause=1, reset_level=1. The frame counter is cleared on entry and increments on each startOfFrame. When the counter reaches RESPAWN_FRAMES -> PLAY. Key edges and collisions are ignored.
  - GAME_OVER: pause=1, reset_level=0, game_over=1. Key edge -> IDLE with score=0, level=0, life=NUM_LIVES, hit counter=0.
  - WIN: same as GAME_OVER but game_won=1 instead of game_over.
- Asserting resetN mid-game from any state forces the reset values immediately, without waiting for a clock edge.

Optional Feature:
GAME_FLOW_BAD_HIT_LIFE_EN
- Defined: a bad event in PLAY costs a life, handled exactly like a bottom event (RESPAWN, or GAME_OVER on the last life). Score is unchanged.
- Undefined: a bad event decrements score, saturating at 0, as specified above.

Test Plan:
1. Reset, then key5IsPressed rising edge -> next cycle state PLAY, pause=0, reset_level=0, life=3, score=0, level=0.
2. In PLAY, hold collisionSmileyObstacleGood high for 200 cycles within one frame, then again in the next frame -> score goes 0->1->2, once per frame, not per cycle.
3. Three good events with HITS_PER_LEVEL=3 -> level=1, reset_level=1 for exactly 60 startOfFrame pulses, then PLAY. Repeat up to level 3 -> WIN, game_won=1.
4. Three bottom events starting from life=3 -> life 2 (RESPAWN), 1 (RESPAWN), 0 (GAME_OVER, game_over=1). Next key edge -> IDLE, life=3, score=0.
5. Bottom and good high in the same cycle with score=5 and life=3 -> life=2, score stays 5. Bad event at score=0 -> score stays 0; with GAME_FLOW_BAD_HIT_LIFE_EN defined -> life decrements instead.
6. In PLAY, key edge -> PAUSED; good collision held -> score unchanged. Second key edge -> PLAY. Assert resetN mid-RESPAWN -> outputs at reset values with no clock edge needed.
